// File: rtl/reset_sequencer_if.sv
// Bundles the reset sequencer's request, acknowledge, watchdog and domain-reset signals.
// The master modport belongs to the sequencer; the slave modport belongs to its environment.
interface reset_sequencer_if #(
  parameter int N_DOM = 3
);
  logic             sw_rst_req;
  logic             sw_rst_ack;
  logic             wdt_kick;
  logic [N_DOM-1:0] dom_rst;
  logic             busy;
  logic             wdt_fired;

  modport master (
    input  sw_rst_req, wdt_kick,
    output sw_rst_ack, dom_rst, busy, wdt_fired
  );

  modport slave (
    output sw_rst_req, wdt_kick,
    input  sw_rst_ack, dom_rst, busy, wdt_fired
  );
endinterface

// File: rtl/reset_sequencer.sv
// Holds all reset domains, then releases them one at a time in index order. It restarts on a software request.
// Define RESET_SEQ_WDT_EN to build in the watchdog, which restarts the sequence when it is not kicked.
module reset_sequencer #(
  parameter int N_DOM       = 3,
  parameter int HOLD_CYC    = 16,
  parameter int GAP_CYC     = 4,
  parameter int WDT_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  reset_sequencer_if.master  bus
);

  localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {HOLD, STAGE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_DOM-1:0] dom_q, dom_d;
  logic             ack_q, ack_d;
  logic             restart;
  logic             wdt_tmo;

`ifdef RESET_SEQ_WDT_EN
  localparam int WDT_W = $clog2(WDT_TIMEOUT + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             fired_q, fired_d;

  // A kick on the timeout edge wins over the timeout.
  assign wdt_tmo = (state_q == RUN) && !bus.wdt_kick && (wdt_q == WDT_LAST);
  assign wdt_d   = ((state_q == RUN) && (state_d == RUN) && !bus.wdt_kick) ? wdt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      fired_q <= fired_d;
    end
  end

  assign bus.wdt_fired = fired_q;
`else
  logic [32:0] unused_wdt;

  assign unused_wdt    = {bus.wdt_kick, 32'(WDT_TIMEOUT)};
  assign wdt_tmo       = 1'b0;
  assign bus.wdt_fired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      dom_q   <= '1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dom_d   = dom_q;
    ack_d   = 1'b0;
    restart = 1'b0;
`ifdef RESET_SEQ_WDT_EN
    fired_d = 1'b0;
`endif
    case (state_q)
      HOLD, STAGE: begin
        // Shifting zeros in from bit 0 releases the domains strictly in index order.
        if (cnt_q == ((state_q == HOLD) ? HOLD_LAST : GAP_LAST)) begin
          cnt_d   = '0;
          dom_d   = dom_q << 1;
          state_d = (dom_d == '0) ? RUN : STAGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.sw_rst_req) begin
          ack_d   = 1'b1;
          restart = 1'b1;
        end else if (wdt_tmo) begin
`ifdef RESET_SEQ_WDT_EN
          fired_d = 1'b1;
`endif
          restart = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
    if (restart) begin
      state_d = HOLD;
      cnt_d   = '0;
      dom_d   = '1;
    end
  end

  assign bus.dom_rst    = dom_q;
  assign bus.busy       = |dom_q;
  assign bus.sw_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer. An age-based reference model predicts each cycle's outputs.
// The watchdog cases are active when RESET_SEQ_WDT_EN is defined.
module tb_reset_sequencer;

  localparam int N_DOM   = 3;
  localparam int HOLD    = 16;
  localparam int GAP     = 4;
  localparam int TMO     = 8;
`ifdef RESET_SEQ_WDT_EN
  localparam bit WDT_EN  = 1'b1;
`else
  localparam bit WDT_EN  = 1'b0;
`endif

  typedef struct {
    logic [N_DOM-1:0] dom;
    logic             busy;
    logic             ack;
    logic             fired;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int   m_age = 0;
  int   m_wdt = 0;
  bit   m_run = 1'b0;

  reset_sequencer_if #(.N_DOM(N_DOM)) bus ();

  reset_sequencer #(
    .N_DOM(N_DOM), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .WDT_TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_DOM-1:0] dom_for_age(input int age);
    logic [N_DOM-1:0] ones;
    int rel;
    ones = '1;
    rel  = (age < HOLD) ? 0 : (age - HOLD) / GAP + 1;
    if (rel > N_DOM) rel = N_DOM;
    return ones << rel;
  endfunction

  task automatic model_edge(input bit r, input bit req, input bit kick, output exp_t e);
    e.ack   = 1'b0;
    e.fired = 1'b0;
    if (r) begin
      m_age = 0; m_run = 1'b0; m_wdt = 0;
    end else if (m_run) begin
      if (WDT_EN) m_wdt = kick ? 0 : m_wdt + 1;
      if (req) begin
        e.ack = 1'b1; m_age = 0; m_run = 1'b0; m_wdt = 0;
      end else if (WDT_EN && m_wdt >= TMO) begin
        e.fired = 1'b1; m_age = 0; m_run = 1'b0; m_wdt = 0;
      end
    end else begin
      m_age++;
      if (m_age >= HOLD + (N_DOM - 1) * GAP) begin
        m_run = 1'b1; m_wdt = 0;
      end
    end
    e.dom  = m_run ? '0 : dom_for_age(m_age);
    e.busy = (e.dom != '0);
  endtask

  task automatic step(input bit r, input bit req, input bit kick);
    exp_t e;
    @(negedge clk);
    rst            = r;
    bus.sw_rst_req = req;
    bus.wdt_kick   = kick;
    model_edge(r, req, kick, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("dom_rst",    32'(bus.dom_rst),    32'(e.dom));
    chk("busy",       32'(bus.busy),       32'(e.busy));
    chk("sw_rst_ack", 32'(bus.sw_rst_ack), 32'(e.ack));
    chk("wdt_fired",  32'(bus.wdt_fired),  32'(e.fired));
    chk("ack_fired_excl", 32'(bus.sw_rst_ack & bus.wdt_fired), 32'(0));
  endtask

  task automatic run_to_run(input bit kick);
    int n = 0;
    while (!m_run && n < 100) begin
      step(1'b0, 1'b0, kick);
      n++;
    end
    chk("reach_run", 32'(m_run), 32'(1));
  endtask

  initial begin
    rst            = 1'b1;
    bus.sw_rst_req = 1'b0;
    bus.wdt_kick   = 1'b0;

    // Power-up: reset for 3 cycles, then the 16/4/4 release
    repeat (3) step(1'b1, 1'b0, 1'b1);
    run_to_run(1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);

    // Single-cycle software request
    step(1'b0, 1'b1, 1'b1);
    run_to_run(1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Request held from HOLD start: ignored until the first RUN cycle
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 28; i++) step(1'b0, 1'b1, 1'b1);
    run_to_run(1'b1);

    // Reset pulsed while dom_rst is 3'b100
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 100 && (m_run || m_age < HOLD + GAP); i++) step(1'b0, 1'b0, 1'b1);
    chk("mid_stage_dom", 32'(bus.dom_rst), 32'(3'b100));
    step(1'b1, 1'b0, 1'b1);
    run_to_run(1'b1);

    // Watchdog: no kicks, then a kick every 7 cycles
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    run_to_run(1'b1);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, (i % 7) == 0);

    // Software request on the timeout edge
    run_to_run(1'b1);
    repeat (TMO - 1) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("coincide_ack", 32'(bus.sw_rst_ack), 32'(1));
    chk("coincide_fired", 32'(bus.wdt_fired), 32'(0));
    run_to_run(1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "timeout");
  end

endmodule
